// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the matrix multiplier: serialized load/store requests
// against a word-addressed scratchpad, answered after a fixed latency with a done pulse.
module matrix_mem_responder #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_in,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        start_memory_transaction,
  output logic        done_memory_transaction,
  output logic        err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_we_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Decode of the captured request; the subtract wraps for addresses below the base.
  logic [DATA_W-1:0] word_c;
  logic              legal_c;
  logic [IDX_W-1:0]  idx_c;

  assign word_c  = (addr_q - BASE_ADDR) >> 2;
  assign legal_c = (addr_q[1:0] == 2'b00) && (addr_q >= BASE_ADDR) &&
                   (word_c < DATA_W'(DEPTH));
  assign idx_c   = IDX_W'(word_c);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    done_d     = 1'b0;
    mem_we_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_memory_transaction) begin
          addr_d  = address_in;
          we_d    = we;
          wdata_d = data_in;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        done_d  = 1'b1;
        err_d   = !legal_c;
        state_d = S_RELEASE;
        if (we_q) begin
          mem_we_c = legal_c;
        end else begin
          data_out_d = legal_c ? mem_q[idx_c] : '0;
        end
      end
      S_RELEASE: begin
        // Holding the strobe high must not launch a second request.
        if (!start_memory_transaction) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Scratchpad storage, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[idx_c] <= wdata_q;
    end
  end

  assign data_out                = data_out_q;
  assign done_memory_transaction = done_q;
  assign err                     = err_q;

endmodule
